mux101_scan_collector: RTL and testbench

- Sequencer that sits directly upstream and downstream of the 10:1 single-bit output multiplexer (4-bit select).
- Drives the mux select through channels 0..9 at a programmable pace and samples the mux's 1-bit output after each settle interval.
- Packs the ten samples into a 10-bit word and hands the word downstream with a valid/ready handshake.
- Supports one-shot and continuous scanning.

---
 rtl/mux101_scan_collector_pkg.sv | 15 +
 rtl/mux101_scan_collector_if.sv | 35 +++
 rtl/mux101_scan_divider.sv | 30 +++
 rtl/mux101_scan_collector.sv | 127 ++++++++++++
 tb/tb_mux101_scan_collector.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux101_scan_collector_pkg.sv
// Shared definitions for the mux101 scan collector: state encoding and default geometry.
package mux101_scan_collector_pkg;

  localparam int unsigned SCAN_SELECTWIDTH_DEF = 4;
  localparam int unsigned SCAN_CHANNELS_DEF    = 10;
  localparam int unsigned SCAN_DIVWIDTH_DEF    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } scan_state_t;

endpackage

// File: rtl/mux101_scan_collector_if.sv
// Mux-facing and downstream-facing signals of the scan collector.
// master = collector side, slave = mux/downstream side.
interface mux101_scan_collector_if
  import mux101_scan_collector_pkg::*;
#(
  parameter int unsigned SCAN_SELECTWIDTH = SCAN_SELECTWIDTH_DEF,
  parameter int unsigned SCAN_CHANNELS    = SCAN_CHANNELS_DEF
) ();

  logic [SCAN_SELECTWIDTH-1:0] CC_SCAN_select_OutBUS;
  logic                        CC_SCAN_z_In;
  logic [SCAN_CHANNELS-1:0]    CC_SCAN_word_OutBUS;
  logic                        CC_SCAN_valid_Out;
  logic                        CC_SCAN_ready_In;
  logic                        CC_SCAN_busy_Out;

  modport master (
    output CC_SCAN_select_OutBUS,
    output CC_SCAN_word_OutBUS,
    output CC_SCAN_valid_Out,
    output CC_SCAN_busy_Out,
    input  CC_SCAN_z_In,
    input  CC_SCAN_ready_In
  );

  modport slave (
    input  CC_SCAN_select_OutBUS,
    input  CC_SCAN_word_OutBUS,
    input  CC_SCAN_valid_Out,
    input  CC_SCAN_busy_Out,
    output CC_SCAN_z_In,
    output CC_SCAN_ready_In
  );

endinterface

// File: rtl/mux101_scan_divider.sv
// Loadable down-counter pacing the settle interval; zero_o flags the end of an interval.
module mux101_scan_divider
  import mux101_scan_collector_pkg::*;
#(
  parameter int unsigned SCAN_DIVWIDTH = SCAN_DIVWIDTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic [SCAN_DIVWIDTH-1:0] load_val_i,
  input  logic                     dec_i,
  output logic                     zero_o
);

  logic [SCAN_DIVWIDTH-1:0] count_q;

  // Load has priority over decrement.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - SCAN_DIVWIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/mux101_scan_collector.sv
// Steps the 10:1 mux select through every channel, samples the mux output after
// each settle interval and presents the packed word with a valid/ready handshake.
module mux101_scan_collector
  import mux101_scan_collector_pkg::*;
#(
  parameter int unsigned SCAN_SELECTWIDTH = SCAN_SELECTWIDTH_DEF,
  parameter int unsigned SCAN_CHANNELS    = SCAN_CHANNELS_DEF,
  parameter int unsigned SCAN_DIVWIDTH    = SCAN_DIVWIDTH_DEF
) (
  input  logic                     CC_SCAN_CLOCK_50,
  input  logic                     CC_SCAN_RESET_InLow,
  input  logic                     CC_SCAN_start_In,
  input  logic                     CC_SCAN_continuous_In,
  input  logic [SCAN_DIVWIDTH-1:0] CC_SCAN_divider_InBUS,
  mux101_scan_collector_if.master  bus
);

  scan_state_t                 state_q;
  logic [SCAN_SELECTWIDTH-1:0] sel_q;
  logic [SCAN_CHANNELS-1:0]    shadow_q;
  logic [SCAN_CHANNELS-1:0]    word_q;
  logic                        valid_q;
  logic                        busy_q;
  logic [SCAN_DIVWIDTH-1:0]    div_lat_q;

  logic [SCAN_DIVWIDTH-1:0]    div_eff;
  logic [SCAN_DIVWIDTH-1:0]    cnt_load_val;
  logic [SCAN_CHANNELS-1:0]    shadow_merged;
  logic                        cnt_load;
  logic                        cnt_dec;
  logic                        cnt_zero;
  logic                        last_ch;
  logic                        accept;
  logic                        scan_start;

  // Control decode: scan start (from IDLE or continuous restart), counter load/decrement, sample merge.
  always_comb begin
    div_eff       = (CC_SCAN_divider_InBUS == '0) ? SCAN_DIVWIDTH'(1) : CC_SCAN_divider_InBUS;
    last_ch       = (sel_q == SCAN_SELECTWIDTH'(SCAN_CHANNELS - 1));
    accept        = (state_q == ST_HOLD) && valid_q && bus.CC_SCAN_ready_In;
    scan_start    = ((state_q == ST_IDLE) && CC_SCAN_start_In) ||
                    (accept && CC_SCAN_continuous_In);
    cnt_load      = scan_start || ((state_q == ST_SAMPLE) && !last_ch);
    cnt_load_val  = scan_start ? (div_eff - SCAN_DIVWIDTH'(1))
                               : (div_lat_q - SCAN_DIVWIDTH'(1));
    cnt_dec       = (state_q == ST_SETTLE) && !cnt_zero;
    shadow_merged = shadow_q;
    shadow_merged[sel_q] = bus.CC_SCAN_z_In;
  end

  mux101_scan_divider #(
    .SCAN_DIVWIDTH (SCAN_DIVWIDTH)
  ) u_divider (
    .clk_i      (CC_SCAN_CLOCK_50),
    .rst_ni     (CC_SCAN_RESET_InLow),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Scan sequencer with registered select, word, valid and busy.
  // The divider is relatched on every scan start so mid-scan changes only affect the next scan.
  always_ff @(posedge CC_SCAN_CLOCK_50 or negedge CC_SCAN_RESET_InLow) begin
    if (!CC_SCAN_RESET_InLow) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      shadow_q  <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      div_lat_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (CC_SCAN_start_In) begin
            sel_q     <= '0;
            shadow_q  <= '0;
            div_lat_q <= div_eff;
            busy_q    <= 1'b1;
            state_q   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          shadow_q <= shadow_merged;
          if (last_ch) begin
            word_q  <= shadow_merged;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_HOLD;
          end else begin
            sel_q   <= sel_q + SCAN_SELECTWIDTH'(1);
            state_q <= ST_SETTLE;
          end
        end
        ST_HOLD: begin
          if (accept) begin
            valid_q <= 1'b0;
            if (CC_SCAN_continuous_In) begin
              sel_q     <= '0;
              shadow_q  <= '0;
              div_lat_q <= div_eff;
              busy_q    <= 1'b1;
              state_q   <= ST_SETTLE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.CC_SCAN_select_OutBUS = sel_q;
  assign bus.CC_SCAN_word_OutBUS   = word_q;
  assign bus.CC_SCAN_valid_Out     = valid_q;
  assign bus.CC_SCAN_busy_Out      = busy_q;

endmodule

// File: tb/tb_mux101_scan_collector.sv
// Self-checking bench for mux101_scan_collector: behavioural mux plus timing model
// derived from channel count and effective divider.
module tb_mux101_scan_collector;

  localparam int CH = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        cont;
  logic [15:0] div_in;
  logic        ready;
  logic [9:0]  pat;

  int checks = 0;
  int errors = 0;

  mux101_scan_collector_if #(.SCAN_SELECTWIDTH(4), .SCAN_CHANNELS(10)) bus ();

  mux101_scan_collector #(
    .SCAN_SELECTWIDTH (4),
    .SCAN_CHANNELS    (10),
    .SCAN_DIVWIDTH    (16)
  ) dut (
    .CC_SCAN_CLOCK_50      (clk),
    .CC_SCAN_RESET_InLow   (rst_n),
    .CC_SCAN_start_In      (start),
    .CC_SCAN_continuous_In (cont),
    .CC_SCAN_divider_InBUS (div_in),
    .bus                   (bus.master)
  );

  // Behavioural 10:1 mux driven by the current pattern.
  assign bus.CC_SCAN_z_In     = (bus.CC_SCAN_select_OutBUS < 4'd10) ? pat[bus.CC_SCAN_select_OutBUS] : 1'b0;
  assign bus.CC_SCAN_ready_In = ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Select must never leave the legal channel range.
  always @(negedge clk) begin
    if (rst_n && bus.CC_SCAN_select_OutBUS > 4'd9) begin
      checks++;
      errors++;
      $display("FAIL select_range: got %0d required <= 9", bus.CC_SCAN_select_OutBUS);
    end
  end

  function automatic int exp_latency(input logic [15:0] div);
    int d;
    d = (div == 16'd0) ? 1 : int'(div);
    return CH * (d + 1) + 1;
  endfunction

  // Starts a scan and follows it until valid; records latency and select/busy deviations
  // from the expected channel-per-interval schedule. Optionally pulses start and changes
  // the divider mid-scan.
  task automatic run_scan(input logic [15:0] div, input int start_at, input int chg_at,
                          input logic [15:0] chg_div, output int lat, output int seq_err);
    int d;
    int n;
    d = (div == 16'd0) ? 1 : int'(div);
    div_in  = div;
    seq_err = 0;
    lat     = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 1;
    while (n < 3000) begin
      if (bus.CC_SCAN_valid_Out === 1'b1) begin
        lat = n;
        break;
      end
      if (int'(bus.CC_SCAN_select_OutBUS) != (n - 1) / (d + 1) || bus.CC_SCAN_busy_Out !== 1'b1)
        seq_err++;
      start = (n == start_at);
      if (n == chg_at) div_in = chg_div;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    checks++;
    if ({bus.CC_SCAN_select_OutBUS, bus.CC_SCAN_word_OutBUS, bus.CC_SCAN_valid_Out, bus.CC_SCAN_busy_Out} !== 16'd0) begin
      errors++;
      $display("FAIL reset_initial: got sel=%0d word=%0h valid=%0b busy=%0b required all 0",
               bus.CC_SCAN_select_OutBUS, bus.CC_SCAN_word_OutBUS, bus.CC_SCAN_valid_Out, bus.CC_SCAN_busy_Out);
    end
    rst_n = 1'b1;
    pat = 10'b1011001110;
    div_in = 16'd3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!(bus.CC_SCAN_select_OutBUS == 4'd4 && bus.CC_SCAN_busy_Out === 1'b1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL reset_reach_ch4: got timeout required select=4");
    end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.CC_SCAN_select_OutBUS, bus.CC_SCAN_word_OutBUS, bus.CC_SCAN_valid_Out, bus.CC_SCAN_busy_Out} !== 16'd0) begin
      errors++;
      $display("FAIL reset_async: got sel=%0d word=%0h valid=%0b busy=%0b required all 0",
               bus.CC_SCAN_select_OutBUS, bus.CC_SCAN_word_OutBUS, bus.CC_SCAN_valid_Out, bus.CC_SCAN_busy_Out);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.CC_SCAN_select_OutBUS, bus.CC_SCAN_valid_Out, bus.CC_SCAN_busy_Out} !== 6'd0) begin
      errors++;
      $display("FAIL reset_next_cycle: got sel=%0d valid=%0b busy=%0b required 0",
               bus.CC_SCAN_select_OutBUS, bus.CC_SCAN_valid_Out, bus.CC_SCAN_busy_Out);
    end
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.CC_SCAN_busy_Out !== 1'b0 || bus.CC_SCAN_valid_Out !== 1'b0 || bus.CC_SCAN_select_OutBUS !== 4'd0)
        n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL reset_stays_idle: got %0d active cycles required 0", n);
    end
  endtask

  task automatic test_oneshot();
    int lat, se;
    cont  = 1'b0;
    ready = 1'b1;
    pat   = 10'b1011001110;
    run_scan(16'd3, 0, 0, 16'd0, lat, se);
    checks++;
    if (lat != 41) begin errors++; $display("FAIL oneshot_latency: got %0d required 41", lat); end
    checks++;
    if (se != 0) begin errors++; $display("FAIL oneshot_select_seq: got %0d bad cycles required 0", se); end
    checks++;
    if (bus.CC_SCAN_word_OutBUS !== 10'b1011001110 || bus.CC_SCAN_select_OutBUS !== 4'd9) begin
      errors++;
      $display("FAIL oneshot_word: got %b sel=%0d required 1011001110 sel=9",
               bus.CC_SCAN_word_OutBUS, bus.CC_SCAN_select_OutBUS);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.CC_SCAN_valid_Out !== 1'b0 || bus.CC_SCAN_busy_Out !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_accept: got valid=%0b busy=%0b required 0 0", bus.CC_SCAN_valid_Out, bus.CC_SCAN_busy_Out);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.CC_SCAN_busy_Out !== 1'b0 || bus.CC_SCAN_valid_Out !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_idle: got busy=%0b valid=%0b required 0 0", bus.CC_SCAN_busy_Out, bus.CC_SCAN_valid_Out);
    end
  endtask

  task automatic test_div_zero();
    int lat, se;
    logic [9:0] w0;
    cont  = 1'b0;
    ready = 1'b1;
    pat   = 10'($urandom);
    run_scan(16'd0, 0, 0, 16'd0, lat, se);
    w0 = bus.CC_SCAN_word_OutBUS;
    checks++;
    if (lat != 21 || se != 0) begin
      errors++;
      $display("FAIL divzero_timing: got lat=%0d seq_err=%0d required 21 0", lat, se);
    end
    checks++;
    if (w0 !== pat) begin errors++; $display("FAIL divzero_word: got %h required %h", w0, pat); end
    run_scan(16'd1, 0, 0, 16'd0, lat, se);
    checks++;
    if (lat != 21 || bus.CC_SCAN_word_OutBUS !== pat) begin
      errors++;
      $display("FAIL divone_match: got lat=%0d word=%h required 21 %h", lat, bus.CC_SCAN_word_OutBUS, pat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat, se, bad;
    cont  = 1'b0;
    ready = 1'b0;
    pat   = 10'($urandom);
    run_scan(16'd2, 0, 0, 16'd0, lat, se);
    checks++;
    if (lat != exp_latency(16'd2) || bus.CC_SCAN_word_OutBUS !== pat) begin
      errors++;
      $display("FAIL bp_scan: got lat=%0d word=%h required %0d %h", lat, bus.CC_SCAN_word_OutBUS, exp_latency(16'd2), pat);
    end
    bad = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.CC_SCAN_valid_Out !== 1'b1 || bus.CC_SCAN_word_OutBUS !== pat || bus.CC_SCAN_select_OutBUS !== 4'd9)
        bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles required 0", bad); end
    ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.CC_SCAN_valid_Out !== 1'b0 || bus.CC_SCAN_busy_Out !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: got valid=%0b busy=%0b required 0 0", bus.CC_SCAN_valid_Out, bus.CC_SCAN_busy_Out);
    end
  endtask

  task automatic test_continuous();
    int lat, se, n, d;
    d     = int'($urandom_range(1, 3));
    cont  = 1'b1;
    ready = 1'b1;
    pat   = 10'h3FF;
    run_scan(16'(d), 0, 0, 16'd0, lat, se);
    checks++;
    if (lat != exp_latency(16'(d)) || se != 0 || bus.CC_SCAN_word_OutBUS !== 10'h3FF) begin
      errors++;
      $display("FAIL cont_first: got lat=%0d seq_err=%0d word=%h required %0d 0 3ff",
               lat, se, bus.CC_SCAN_word_OutBUS, exp_latency(16'(d)));
    end
    pat = 10'h000;
    @(posedge clk); #1;
    checks++;
    if (bus.CC_SCAN_valid_Out !== 1'b0 || bus.CC_SCAN_select_OutBUS !== 4'd0 || bus.CC_SCAN_busy_Out !== 1'b1) begin
      errors++;
      $display("FAIL cont_restart: got valid=%0b sel=%0d busy=%0b required 0 0 1",
               bus.CC_SCAN_valid_Out, bus.CC_SCAN_select_OutBUS, bus.CC_SCAN_busy_Out);
    end
    n = 0;
    while (bus.CC_SCAN_valid_Out !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    cont = 1'b0;
    checks++;
    if (n != CH * (d + 1) || bus.CC_SCAN_word_OutBUS !== 10'h000) begin
      errors++;
      $display("FAIL cont_second: got cycles=%0d word=%h required %0d 000", n, bus.CC_SCAN_word_OutBUS, CH * (d + 1));
    end
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.CC_SCAN_valid_Out !== 1'b0 || bus.CC_SCAN_busy_Out !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop: got valid=%0b busy=%0b required 0 0", bus.CC_SCAN_valid_Out, bus.CC_SCAN_busy_Out);
    end
  endtask

  task automatic test_ignored_start();
    int lat, se;
    cont  = 1'b0;
    ready = 1'b0;
    pat   = 10'($urandom);
    run_scan(16'd2, 5, 3, 16'd7, lat, se);
    checks++;
    if (lat != 31 || se != 0 || bus.CC_SCAN_word_OutBUS !== pat) begin
      errors++;
      $display("FAIL ignstart_scan: got lat=%0d seq_err=%0d word=%h required 31 0 %h",
               lat, se, bus.CC_SCAN_word_OutBUS, pat);
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++;
    if (bus.CC_SCAN_valid_Out !== 1'b1 || bus.CC_SCAN_select_OutBUS !== 4'd9 || bus.CC_SCAN_busy_Out !== 1'b0) begin
      errors++;
      $display("FAIL ignstart_hold: got valid=%0b sel=%0d busy=%0b required 1 9 0",
               bus.CC_SCAN_valid_Out, bus.CC_SCAN_select_OutBUS, bus.CC_SCAN_busy_Out);
    end
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.CC_SCAN_valid_Out !== 1'b0 || bus.CC_SCAN_busy_Out !== 1'b0 || bus.CC_SCAN_select_OutBUS !== 4'd9) begin
      errors++;
      $display("FAIL ignstart_with_ready: got valid=%0b busy=%0b sel=%0d required 0 0 9",
               bus.CC_SCAN_valid_Out, bus.CC_SCAN_busy_Out, bus.CC_SCAN_select_OutBUS);
    end
  endtask

  task automatic test_random();
    int lat, se;
    logic [15:0] dv;
    cont  = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dv  = 16'($urandom_range(0, 5));
      pat = 10'($urandom);
      run_scan(dv, 0, 0, 16'd0, lat, se);
      checks++;
      if (lat != exp_latency(dv) || se != 0 || bus.CC_SCAN_word_OutBUS !== pat) begin
        errors++;
        $display("FAIL random_scan[%0d]: got lat=%0d seq_err=%0d word=%h required %0d 0 %h (div=%0d)",
                 i, lat, se, bus.CC_SCAN_word_OutBUS, exp_latency(dv), pat, dv);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    cont   = 1'b0;
    ready  = 1'b0;
    div_in = 16'd0;
    pat    = 10'd0;
    #23;
    test_reset();
    test_oneshot();
    test_div_zero();
    test_backpressure();
    test_continuous();
    test_ignored_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
